// File: rtl/flat_inst_queue_pkg.sv
// Shared types for the FLAT/GLOBAL/SCRATCH instruction queue: instruction word,
// address-space tag and the SEG-to-space decode.
package flat_inst_queue_pkg;

    typedef enum logic [1:0] {
        FLAT_SPACE_FLAT    = 2'd0,
        FLAT_SPACE_SCRATCH = 2'd1,
        FLAT_SPACE_GLOBAL  = 2'd2
    } flat_space_t;

    localparam logic [1:0] FLAT_SEG_RESERVED = 2'b11;

    typedef struct packed {
        logic [1:0]  seg;
        logic [6:0]  op;
        logic [7:0]  vdst;
        logic [7:0]  vaddr;
        logic [12:0] offset;
    } flat_inst_t;

    // Reserved SEG never reaches storage, so its mapping here is irrelevant.
    function automatic flat_space_t seg_to_space(input logic [1:0] seg);
        case (seg)
            2'b01:   return FLAT_SPACE_SCRATCH;
            2'b10:   return FLAT_SPACE_GLOBAL;
            default: return FLAT_SPACE_FLAT;
        endcase
    endfunction

endpackage

// File: rtl/flat_inst_queue_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; head entry is read
// combinationally from storage (no output register).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Flush takes priority: a same-cycle pop is discarded along with the contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + PTR_W'(1);
            if (pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wptr] <= wdata;
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;

endmodule

// File: rtl/flat_inst_queue.sv
// Queue between decode_flat and memory-unit address generation: decodes SEG to
// an address-space tag, drops reserved-segment instructions, backpressures via stall.
module flat_inst_queue
    import flat_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  flat_inst_t       in_inst,
    input  logic             in_valid,
    output logic             stall_out,
    output flat_inst_t       out_inst,
    output flat_space_t      out_space,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             err_illegal_seg
);
    localparam int INST_W  = $bits(flat_inst_t);
    localparam int SPACE_W = $bits(flat_space_t);
    localparam int ENTRY_W = INST_W + SPACE_W;

    logic               w_push;
    logic               w_pop;
    logic               w_illegal;
    logic               w_store;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    logic [CNT_W-1:0]   w_count;
    logic               r_err;

    assign w_illegal = (in_inst.seg == FLAT_SEG_RESERVED);
    assign w_push    = in_valid && !stall_out;
    assign w_store   = w_push && !w_illegal;
    assign w_pop     = out_valid && out_ready;
    assign w_wdata   = {seg_to_space(in_inst.seg), in_inst};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_store),
        .pop   (w_pop),
        .flush (flush),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .count (w_count)
    );

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     r_err <= 1'b0;
        else if (w_push && w_illegal)  r_err <= 1'b1;
    end

    assign count           = w_count;
    assign out_valid       = (w_count != '0);
    assign stall_out       = (w_count == CNT_W'(DEPTH)) || flush;
    assign out_inst        = out_valid ? flat_inst_t'(w_rdata[INST_W-1:0]) : '0;
    assign out_space       = out_valid ? flat_space_t'(w_rdata[ENTRY_W-1:INST_W]) : FLAT_SPACE_FLAT;
    assign err_illegal_seg = r_err;

    a_push_not_full: assert property (@(posedge clk) disable iff (reset)
        w_push |-> (w_count < CNT_W'(DEPTH)));
    a_pop_not_empty: assert property (@(posedge clk) disable iff (reset)
        w_pop |-> (w_count > '0));

endmodule

// File: tb/tb_flat_inst_queue.sv
// Randomized and directed bench for flat_inst_queue against a queue-based reference model.
module tb_flat_inst_queue;
    import flat_inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    flat_inst_t       in_inst;
    logic             in_valid;
    logic             stall_out;
    flat_inst_t       out_inst;
    flat_space_t      out_space;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             err_illegal_seg;

    flat_inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_inst         (in_inst),
        .in_valid        (in_valid),
        .stall_out       (stall_out),
        .out_inst        (out_inst),
        .out_space       (out_space),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .count           (count),
        .err_illegal_seg (err_illegal_seg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    flat_inst_t mq[$];
    bit         merr;
    bit         last_push;
    bit         wrap_on;
    int         wrap_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_space_of(input logic [1:0] seg);
        if (seg == 2'b01)      return 2'd1;
        else if (seg == 2'b10) return 2'd2;
        else                   return 2'd0;
    endfunction

    task automatic check_outputs();
        bit         ev;
        flat_inst_t ei;
        logic [1:0] es;
        ev = (mq.size() > 0);
        ei = ev ? mq[0] : '0;
        es = ev ? exp_space_of(mq[0].seg) : 2'd0;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_inst",  64'(out_inst),  64'(ei));
        if (ev) chk("out_space", 64'(out_space), 64'(es));
        chk("count",     64'(count),     64'(mq.size()));
        chk("stall_out", 64'(stall_out), 64'((mq.size() == DEPTH) || flush));
        chk("err_seg",   64'(err_illegal_seg), 64'(merr));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit         push;
        bit         pop;
        flat_inst_t popped;
        #1;
        check_outputs();
        push = in_valid && !((mq.size() == DEPTH) || flush);
        pop  = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                popped = mq.pop_front();
                if (wrap_on) begin
                    chk("wrap_order", 64'(popped.op), 64'(wrap_exp));
                    wrap_exp++;
                end
            end
            if (push) begin
                if (in_inst.seg == 2'b11) merr = 1'b1;
                else                      mq.push_back(in_inst);
            end
        end
        last_push = push;
        @(negedge clk);
    endtask

    function automatic flat_inst_t mk(input logic [1:0] seg, input logic [6:0] op, input logic [7:0] vdst);
        flat_inst_t t;
        t.seg    = seg;
        t.op     = op;
        t.vdst   = vdst;
        t.vaddr  = 8'($urandom);
        t.offset = 13'($urandom);
        return t;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
        merr = 1'b0; last_push = 1'b0; wrap_on = 1'b0; wrap_exp = 0;
        repeat (2) @(negedge clk);
        #1 check_outputs();
        reset = 1'b0;

        // single push into empty queue
        in_valid = 1'b1; out_ready = 1'b1; in_inst = mk(2'b10, 7'h1C, 8'h05);
        step();
        in_valid = 1'b0;
        step();
        step();

        // fill, hold while stalled, one pop lets the held instruction in once
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_inst = mk(2'($urandom_range(0, 2)), 7'(i), 8'(i));
            step();
        end
        in_inst = mk(2'b01, 7'h55, 8'hAA);
        repeat (3) step();
        out_ready = 1'b1; step();
        out_ready = 1'b0; step();
        in_valid = 1'b0; step();
        out_ready = 1'b1;
        repeat (5) step();

        // reserved segment dropped, error sticky across flush
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = mk(2'b11, 7'h11, 8'h22); step();
        in_inst = mk(2'b00, 7'h12, 8'h23); step();
        in_valid = 1'b0; step();
        flush = 1'b1; step();
        flush = 1'b0; step();

        // pointer wrap: ten instructions in order with toggling ready
        wrap_on = 1'b1;
        begin
            int idx = 0;
            for (int c = 0; c < 60; c++) begin
                out_ready = (c % 2 == 0);
                in_valid  = (idx < 10);
                if (idx < 10 && (c == 0 || last_push || in_inst.op != 7'(idx)))
                    in_inst = mk(2'(idx % 3), 7'(idx), 8'(idx));
                step();
                if (last_push && idx < 10) idx++;
            end
        end
        wrap_on = 1'b0;
        chk("wrap_total", 64'(wrap_exp), 64'd10);

        // flush with three queued and ready high
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = mk(2'b10, 7'(20 + i), 8'(i)); step();
        end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0; step();

        // asynchronous reset mid-cycle with two queued and error set
        out_ready = 1'b0; in_valid = 1'b1; in_inst = mk(2'b11, 7'h3, 8'h3); step();
        for (int i = 0; i < 2; i++) begin
            in_inst = mk(2'b01, 7'(30 + i), 8'(i)); step();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", 64'(out_valid), 64'd0);
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_stall", 64'(stall_out), 64'd0);
        chk("areset_err",   64'(err_illegal_seg), 64'd0);
        mq.delete(); merr = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // randomized traffic; producer holds its instruction while stalled
        in_valid = 1'b0; last_push = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(in_valid && !last_push)) begin
                in_valid = ($urandom_range(0, 9) < 6);
                in_inst  = mk(($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                              7'($urandom), 8'($urandom));
            end
            out_ready = $urandom_range(0, 1);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
